// File: rtl/ntt_pkg.sv
//------------------------------------------------------------------------------
// ntt_pkg : shared NTT datapath constants, FSM encoding and tag-width helper
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ntt_pkg;

  localparam int NTT_W     = 17;
  localparam int Q_DEFAULT = 7681;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // ceil(log2(n)), never less than 1
  function automatic int tag_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : round-robin pick of the first request at or above ptr, with wrap
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import ntt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TW   = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [TW-1:0]   idx,
  output logic            any_grant
);

  localparam int IW = tag_width(NREQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = TW'(cand);
        found       = 1'b1;
      end
    end
  end

  assign any_grant = found;

endmodule

`default_nettype wire

// File: rtl/mont_mul_arbiter.sv
//------------------------------------------------------------------------------
// mont_mul_arbiter : shares one LAT-cycle Montgomery multiplier among NREQ
//                    requesters, routes results back by tag, owns modulus Q
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_mul_arbiter
  import ntt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = NTT_W,
  parameter int LAT  = 5,
  parameter int TW   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  input  logic              cfg_valid,
  input  logic [W-1:0]      cfg_q,
  output logic              cfg_ready,
  output logic [W-1:0]      q_out,
  output logic              mul_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_res,
  output logic              busy
);

  state_e                  state_q, state_d;
  logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                    mul_valid_q, mul_valid_d;
  logic [W-1:0]            mul_a_q, mul_a_d;
  logic [W-1:0]            mul_b_q, mul_b_d;
  logic [TW-1:0]           issue_tag_q, issue_tag_d;
  logic [LAT-1:0]          pipe_v_q, pipe_v_d;
  logic [LAT-1:0][TW-1:0]  pipe_tag_q, pipe_tag_d;
  logic [W-1:0]            q_out_q, q_out_d;

  logic [NREQ-1:0]         arb_grant;
  logic [TW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    grant_en;
  logic                    xfer;

  rr_arbiter #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_grant (arb_any)
  );

  // A pending cfg_valid blocks new issue so the drain can make progress
  assign grant_en  = reset_n && (state_q == ST_RUN) && !cfg_valid;
  assign req_ready = grant_en ? arb_grant : '0;
  assign xfer      = grant_en && arb_any;

  always_comb begin
    mul_valid_d = xfer;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    issue_tag_d = issue_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      for (int i = 0; i < NREQ; i++) begin
        if (arb_grant[i]) begin
          mul_a_d = req_a[i*W +: W];
          mul_b_d = req_b[i*W +: W];
        end
      end
      issue_tag_d = arb_idx;
      rr_ptr_d    = TW'((int'(arb_idx) + 1) % NREQ);
    end
  end

  always_comb begin
    pipe_v_d      = '0;
    pipe_tag_d    = '0;
    pipe_v_d[0]   = mul_valid_q;
    pipe_tag_d[0] = issue_tag_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  // Last stage lines up with the multiplier's output cycle
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pipe_v_q[LAT-1]) begin
      rsp_data = mul_res;
      for (int i = 0; i < NREQ; i++) begin
        if (pipe_tag_q[LAT-1] == TW'(i)) rsp_valid[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    q_out_d   = q_out_q;
    cfg_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!cfg_valid)       state_d = ST_RUN;
        else if (~|pipe_v_q)  state_d = ST_LOAD;
      end
      ST_LOAD: begin
        q_out_d   = cfg_q;
        cfg_ready = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      rr_ptr_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_tag_q <= '0;
      pipe_v_q    <= '0;
      pipe_tag_q  <= '0;
      q_out_q     <= W'(Q_DEFAULT);
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      issue_tag_q <= issue_tag_d;
      pipe_v_q    <= pipe_v_d;
      pipe_tag_q  <= pipe_tag_d;
      q_out_q     <= q_out_d;
    end
  end

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign q_out     = q_out_q;
  assign busy      = (state_q != ST_RUN) || (|pipe_v_q);

endmodule

`default_nettype wire

// File: tb/tb_mont_mul_arbiter.sv
//------------------------------------------------------------------------------
// tb_mont_mul_arbiter : directed bench with a stand-in fixed-latency multiplier
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mont_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 17;
  localparam int LAT  = 5;
  localparam int TW   = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              cfg_valid;
  logic [W-1:0]      cfg_q;
  logic              cfg_ready;
  logic [W-1:0]      q_out;
  logic              mul_valid;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [W-1:0]      mul_res;
  logic              busy;

  always #5 clk = ~clk;

  mont_mul_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .LAT  (LAT),
    .TW   (TW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .cfg_valid (cfg_valid),
    .cfg_q     (cfg_q),
    .cfg_ready (cfg_ready),
    .q_out     (q_out),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_res   (mul_res),
    .busy      (busy)
  );

  // Multiplier stand-in: returns 55 or a+b, LAT cycles after issue
  logic         model_fixed;
  logic [W-1:0] mp [LAT];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else begin
      mp[0] <= mul_valid ? (model_fixed ? W'(55) : W'(mul_a + mul_b)) : '0;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_res = mp[LAT-1];

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] vec;
    logic [W-1:0]    data;
  } ev_t;

  ev_t gnt_q[$];
  ev_t rsp_q[$];
  int  cyc     = 0;
  int  cfg_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t e;
    if (|(req_valid & req_ready)) begin
      e.cyc = cyc; e.vec = req_valid & req_ready; e.data = '0;
      gnt_q.push_back(e);
    end
    if (|rsp_valid) begin
      e.cyc = cyc; e.vec = rsp_valid; e.data = rsp_data;
      rsp_q.push_back(e);
    end
    if (cfg_ready) cfg_cnt = cfg_cnt + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input int a, input int b);
    req_a[r*W +: W] = W'(a);
    req_b[r*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    cfg_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, r0, s, ld, c0;
    bit  seen;

    reset_n     = 1'b0;
    req_valid   = 4'hF;
    req_a       = '0;
    req_b       = '0;
    cfg_valid   = 1'b0;
    cfg_q       = '0;
    model_fixed = 1'b1;

    // Reset state, with requests pending to show grants stay off
    step();
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mul_valid", mul_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_ready", cfg_ready, 0);
    check_eq("rst_q_out", q_out, 7681);
    step();
    req_valid = '0;
    reset_n   = 1'b1;

    // Single op from requester 2
    set_ops(2, 100, 200);
    req_valid = 4'b0100;
    n0 = gnt_q.size(); r0 = rsp_q.size();
    @(negedge clk);
    check_eq("t1_req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_mul_valid", mul_valid, 1);
    check_eq("t1_mul_a", mul_a, 100);
    check_eq("t1_mul_b", mul_b, 200);
    repeat (10) step();
    check_eq("t1_rsp_cnt", rsp_q.size() - r0, 1);
    if (rsp_q.size() > r0 && gnt_q.size() > n0) begin
      check_eq("t1_latency", rsp_q[r0].cyc - gnt_q[n0].cyc, 6);
      check_eq("t1_rsp_vec", rsp_q[r0].vec, 4'b0100);
      check_eq("t1_rsp_data", rsp_q[r0].data, 55);
    end
    check_eq("t1_busy_idle", busy, 0);

    // Full contention for 8 cycles after a fresh reset
    do_reset();
    model_fixed = 1'b0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 20 + i);
    req_valid = 4'hF;
    s  = cyc;
    n0 = gnt_q.size(); r0 = rsp_q.size();
    repeat (8) step();
    req_valid = '0;
    repeat (12) step();
    check_eq("t2_gnt_cnt", gnt_q.size() - n0, 8);
    check_eq("t2_rsp_cnt", rsp_q.size() - r0, 8);
    for (int k = 0; k < 8; k++) begin
      if (gnt_q.size() > n0 + k) begin
        check_eq("t2_gnt_vec", gnt_q[n0+k].vec, 1 << (k % 4));
        check_eq("t2_gnt_cyc", gnt_q[n0+k].cyc, s + k);
      end
      if (rsp_q.size() > r0 + k) begin
        check_eq("t2_rsp_vec", rsp_q[r0+k].vec, 1 << (k % 4));
        check_eq("t2_rsp_cyc", rsp_q[r0+k].cyc, s + k + 6);
        check_eq("t2_rsp_data", rsp_q[r0+k].data, 30 + 2 * (k % 4));
      end
    end

    // Rotation: after grant to 1, requesters 0 and 3 -> 3 then 0
    n0 = gnt_q.size();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1001;
    @(negedge clk);
    check_eq("t3_ready_3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (10) step();
    check_eq("t3_gnt_cnt", gnt_q.size() - n0, 3);
    if (gnt_q.size() >= n0 + 3) begin
      check_eq("t3_gnt0", gnt_q[n0].vec, 4'b0010);
      check_eq("t3_gnt1", gnt_q[n0+1].vec, 4'b1000);
      check_eq("t3_gnt2", gnt_q[n0+2].vec, 4'b0001);
    end

    // Reconfigure with three ops in flight (pointer at 1: grants 1,2,0)
    r0 = rsp_q.size();
    req_valid = 4'b0111;
    repeat (3) step();
    cfg_valid = 1'b1;
    cfg_q     = W'(12289);
    req_valid = 4'hF;
    seen = 1'b0;
    ld   = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (cfg_ready) begin
        seen = 1'b1;
        ld   = cyc;
        check_eq("t4_rsp_before_load", rsp_q.size() - r0, 3);
        check_eq("t4_q_old_in_load", q_out, 7681);
        check_eq("t4_no_grant_load", req_ready, 0);
      end else begin
        check_eq("t4_no_grant_drain", req_ready, 0);
        check_eq("t4_busy_drain", busy, 1);
      end
      step();
    end
    check_eq("t4_cfg_ready_seen", seen, 1);
    cfg_valid = 1'b0;
    if (rsp_q.size() >= r0 + 3) begin
      check_eq("t4_load_cyc", ld, rsp_q[r0+2].cyc + 2);
      check_eq("t4_rsp0", rsp_q[r0].vec, 4'b0010);
      check_eq("t4_rsp1", rsp_q[r0+1].vec, 4'b0100);
      check_eq("t4_rsp2", rsp_q[r0+2].vec, 4'b0001);
      check_eq("t4_rsp1_data", rsp_q[r0+1].data, 34);
    end
    @(negedge clk);
    check_eq("t4_q_new", q_out, 12289);
    check_eq("t4_cfg_pulse_end", cfg_ready, 0);
    check_eq("t4_grant_resume", req_ready, 4'b0010);
    step();
    req_valid = '0;
    repeat (10) step();

    // Reset with two ops in flight
    r0 = rsp_q.size();
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t5_busy_inflight", busy, 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (12) step();
    check_eq("t5_no_rsp", rsp_q.size() - r0, 0);
    check_eq("t5_q_out", q_out, 7681);
    check_eq("t5_busy", busy, 0);
    req_valid = 4'hF;
    @(negedge clk);
    check_eq("t5_ptr_zero", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (10) step();

    // Aborted reconfiguration
    r0 = rsp_q.size();
    c0 = cfg_cnt;
    req_valid = 4'b0001;
    step();
    step();
    cfg_valid = 1'b1;
    cfg_q     = W'(999);
    req_valid = 4'hF;
    @(negedge clk);
    check_eq("t6_no_grant_a", req_ready, 0);
    step();
    @(negedge clk);
    check_eq("t6_no_grant_b", req_ready, 0);
    check_eq("t6_busy_drain", busy, 1);
    step();
    cfg_valid = 1'b0;
    req_valid = '0;
    repeat (12) step();
    check_eq("t6_no_cfg_ready", cfg_cnt - c0, 0);
    check_eq("t6_q_unchanged", q_out, 7681);
    check_eq("t6_rsp_cnt", rsp_q.size() - r0, 2);
    check_eq("t6_busy_idle", busy, 0);
    req_valid = 4'b0001;
    @(negedge clk);
    check_eq("t6_run_again", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
